// File: rtl/l1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// l1_mem_arbiter
//   Shares a single L2 / physical-memory block port between the L1 I-cache and
//   the L1 D-cache. A three-state FSM (IDLE, GNT_I, GNT_D) grants one requester
//   at a time and alternates between them when both are waiting. Every
//   transaction ends with one IDLE cycle before the next grant. Two saturating
//   counters record how many cycles each requester waited without a grant.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_read/i_write/i_addr/i_wdata   I-cache block request
//   i_rdata, i_resp                 I-cache read block and done pulse
//   d_read/d_write/d_addr/d_wdata   D-cache block request
//   d_rdata, d_resp                 D-cache read block and done pulse
//   l2_read/l2_write/l2_addr/
//   l2_wdata                        downstream request, driven from the grant
//   l2_rdata, l2_resp               downstream read block and done pulse
//   i_stall_cnt, d_stall_cnt        saturating wait-cycle counters
// -----------------------------------------------------------------------------
module l1_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int BLOCK_W = 128,
  parameter int CNT_W   = 16,
  parameter int D_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_read,
  input  logic               i_write,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [BLOCK_W-1:0] i_wdata,
  output logic [BLOCK_W-1:0] i_rdata,
  output logic               i_resp,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BLOCK_W-1:0] d_wdata,
  output logic [BLOCK_W-1:0] d_rdata,
  output logic               d_resp,
  output logic               l2_read,
  output logic               l2_write,
  output logic [ADDR_W-1:0]  l2_addr,
  output logic [BLOCK_W-1:0] l2_wdata,
  input  logic [BLOCK_W-1:0] l2_rdata,
  input  logic               l2_resp,
  output logic [CNT_W-1:0]   i_stall_cnt,
  output logic [CNT_W-1:0]   d_stall_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  // last_gnt encoding: 0 = I-cache served last, 1 = D-cache served last.
  // Seeding it with the opposite of the preferred side makes that side win the
  // first contended grant.
  localparam logic LAST_GNT_RST = (D_FIRST != 0) ? 1'b0 : 1'b1;

  logic [1:0] state, state_nxt;
  logic       last_gnt, last_gnt_nxt;
  logic       i_req, d_req;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  // Read data is a straight wire; it is meaningful only while the matching
  // resp is high.
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  always_comb begin
    // NOTE: every output of this block is assigned a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (i_req && d_req) state_nxt = last_gnt ? GNT_I : GNT_D;
        else if (i_req)     state_nxt = GNT_I;
        else if (d_req)     state_nxt = GNT_D;
      end
      GNT_I: begin
        if (l2_resp) begin
          state_nxt    = IDLE;
          last_gnt_nxt = 1'b0;
        end
      end
      GNT_D: begin
        if (l2_resp) begin
          state_nxt    = IDLE;
          last_gnt_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Downstream steering depends on state only, so an asynchronous reset drops
  // the strobes and resps in the same instant. A simultaneous read and write
  // is forwarded as a write. If the granted requester drops its strobes the
  // grant is held and the (now low) strobes are forwarded until L2 answers.
  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    l2_addr  = '0;
    l2_wdata = '0;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    case (state)
      GNT_I: begin
        l2_read  = i_read & ~i_write;
        l2_write = i_write;
        l2_addr  = i_addr;
        l2_wdata = i_wdata;
        i_resp   = l2_resp;
      end
      GNT_D: begin
        l2_read  = d_read & ~d_write;
        l2_write = d_write;
        l2_addr  = d_addr;
        l2_wdata = d_wdata;
        d_resp   = l2_resp;
      end
      default: ;
    endcase
  end

  // NOTE: all state, including the perf counters, is cleared by rst_n so the
  // counters always start a measurement window from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= LAST_GNT_RST;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // A requester is stalling whenever it asks and is not the one granted; this
  // includes the IDLE arbitration cycle every request passes through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_stall_cnt <= '0;
      d_stall_cnt <= '0;
    end else begin
      if (i_req && (state != GNT_I) && (i_stall_cnt != {CNT_W{1'b1}}))
        i_stall_cnt <= i_stall_cnt + 1'b1;
      if (d_req && (state != GNT_D) && (d_stall_cnt != {CNT_W{1'b1}}))
        d_stall_cnt <= d_stall_cnt + 1'b1;
    end
  end

endmodule
